// File: rtl/class_valmem_arb.sv
// class_valmem_arb
//   Shares value-memory port B between the software PIO path (sw) and the
//   insert/remove update engine (upd). One transaction is in flight at a time.
//   Grants are round-robin when both requesters are eligible. upd_lock keeps
//   sw out so that upd can run read-modify-write sequences atomically. Read
//   data returns on the granted requester's rdata with a one-cycle ack pulse.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   sw_req/we/addr/wdata           sw request; fields stable while req is high
//   sw_ack, sw_rdata               sw completion pulse; rdata held until the next sw read ack
//   upd_req/we/addr/wdata          upd request; same rules as sw
//   upd_lock                       while high (sampled in IDLE), sw is not granted
//   upd_ack, upd_rdata             upd completion pulse and read data
//   mem_en/we/addr/wdata           port B command, one-cycle registered pulse per transaction
//   mem_rdata                      port B read data, valid RD_LAT cycles after mem_en
//   busy                           high whenever the FSM is not in IDLE
module class_valmem_arb #(
  parameter int AW     = 15,
  parameter int DW     = 320,
  parameter int RD_LAT = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sw_req,
  input  logic          sw_we,
  input  logic [AW-1:0] sw_addr,
  input  logic [DW-1:0] sw_wdata,
  output logic          sw_ack,
  output logic [DW-1:0] sw_rdata,
  input  logic          upd_req,
  input  logic          upd_we,
  input  logic [AW-1:0] upd_addr,
  input  logic [DW-1:0] upd_wdata,
  input  logic          upd_lock,
  output logic          upd_ack,
  output logic [DW-1:0] upd_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  // Counter only has to hold RD_LAT-1; keep at least one bit for RD_LAT == 1.
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_ACK   = 2'd3;

  localparam logic GNT_SW  = 1'b0;
  localparam logic GNT_UPD = 1'b1;

  logic [1:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          gnt_q, gnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          sw_ack_q, sw_ack_d;
  logic          upd_ack_q, upd_ack_d;
  logic [DW-1:0] sw_rdata_q, sw_rdata_d;
  logic [DW-1:0] upd_rdata_q, upd_rdata_d;
  logic          busy_q, busy_d;

  logic          elig_sw_s;
  logic          elig_upd_s;
  logic          pick_s;

  // Round-robin pick: with both eligible, the one not served last wins.
  always_comb begin
    elig_sw_s  = sw_req & ~upd_lock;
    elig_upd_s = upd_req;
    if (elig_sw_s & elig_upd_s) begin
      pick_s = ~last_grant_q;
    end else if (elig_upd_s) begin
      pick_s = GNT_UPD;
    end else begin
      pick_s = GNT_SW;
    end
  end

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    cnt_d        = cnt_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    sw_ack_d     = 1'b0;
    upd_ack_d    = 1'b0;
    sw_rdata_d   = sw_rdata_q;
    upd_rdata_d  = upd_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (elig_sw_s | elig_upd_s) begin
          // The mem_* registers double as the latched request fields.
          state_d      = S_ISSUE;
          gnt_d        = pick_s;
          last_grant_d = pick_s;
          mem_en_d     = 1'b1;
          if (pick_s == GNT_UPD) begin
            mem_we_d    = upd_we;
            mem_addr_d  = upd_addr;
            mem_wdata_d = upd_wdata;
          end else begin
            mem_we_d    = sw_we;
            mem_addr_d  = sw_addr;
            mem_wdata_d = sw_wdata;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (mem_we_q) begin
          state_d   = S_ACK;
          sw_ack_d  = (gnt_q == GNT_SW);
          upd_ack_d = (gnt_q == GNT_UPD);
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_ZERO) begin
          state_d   = S_ACK;
          sw_ack_d  = (gnt_q == GNT_SW);
          upd_ack_d = (gnt_q == GNT_UPD);
          if (gnt_q == GNT_UPD) begin
            upd_rdata_d = mem_rdata;
          end else begin
            sw_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Registered from the next state so busy lines up with the FSM state.
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GNT_SW;
      gnt_q        <= GNT_SW;
      cnt_q        <= {CW{1'b0}};
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {AW{1'b0}};
      mem_wdata_q  <= {DW{1'b0}};
      sw_ack_q     <= 1'b0;
      upd_ack_q    <= 1'b0;
      sw_rdata_q   <= {DW{1'b0}};
      upd_rdata_q  <= {DW{1'b0}};
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      cnt_q        <= cnt_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      sw_ack_q     <= sw_ack_d;
      upd_ack_q    <= upd_ack_d;
      sw_rdata_q   <= sw_rdata_d;
      upd_rdata_q  <= upd_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign sw_ack    = sw_ack_q;
  assign sw_rdata  = sw_rdata_q;
  assign upd_ack   = upd_ack_q;
  assign upd_rdata = upd_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_class_valmem_arb.sv
// Directed bench for class_valmem_arb with a behavioural port-B memory model.
module tb_class_valmem_arb;
  localparam int AW     = 15;
  localparam int DW     = 320;
  localparam int RD_LAT = 5;
  localparam logic [DW-1:0] JUNK    = {10{32'hDEAD_BEEF}};
  localparam logic [DW-1:0] PAT_A5  = {40{8'hA5}};
  localparam logic [DW-1:0] PAT_100 = {10{32'h0100_C0DE}};
  localparam logic [DW-1:0] PAT_7FF = {10{32'h7FFF_5A5A}};
  localparam logic [DW-1:0] PAT_W4  = {10{32'h4444_0001}};
  localparam logic [DW-1:0] PAT_SW2 = {10{32'h2020_2020}};
  localparam logic [DW-1:0] PAT_UP2 = {10{32'h3030_3030}};
  localparam logic [DW-1:0] VAL_1234 = {{(DW-16){1'b0}}, 16'h1234};
  localparam logic [DW-1:0] ZERO    = {DW{1'b0}};

  logic          clk = 1'b0;
  logic          rst;
  logic          sw_req, sw_we, sw_ack;
  logic [AW-1:0] sw_addr;
  logic [DW-1:0] sw_wdata, sw_rdata;
  logic          upd_req, upd_we, upd_lock, upd_ack;
  logic [AW-1:0] upd_addr;
  logic [DW-1:0] upd_wdata, upd_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  class_valmem_arb #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst),
    .sw_req(sw_req), .sw_we(sw_we), .sw_addr(sw_addr), .sw_wdata(sw_wdata),
    .sw_ack(sw_ack), .sw_rdata(sw_rdata),
    .upd_req(upd_req), .upd_we(upd_we), .upd_addr(upd_addr), .upd_wdata(upd_wdata),
    .upd_lock(upd_lock), .upd_ack(upd_ack), .upd_rdata(upd_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Port-B model: stage 0 carries read data only for a real read, so a
  // sample taken at the wrong latency picks up JUNK.
  logic [DW-1:0] mem_model [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe [0:RD_LAT-1];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) mem_model[pl_addr] <= pl_data;
    else if (mem_en && mem_we) mem_model[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) rd_pipe[0] <= mem_model[mem_addr];
    else rd_pipe[0] <= JUNK;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  // Event logs captured on the falling edge.
  int            en_cyc[$];
  logic          en_we[$];
  logic [AW-1:0] en_addr[$];
  logic [DW-1:0] en_wdata[$];
  int            ack_cyc[$];
  logic          ack_upd[$];
  int            overlap_cnt = 0;
  int            double_en_cnt = 0;
  int            upd_ack_cnt = 0;
  logic          en_prev = 1'b0;
  always @(negedge clk) begin
    if (mem_en) begin
      en_cyc.push_back(cyc); en_we.push_back(mem_we);
      en_addr.push_back(mem_addr); en_wdata.push_back(mem_wdata);
    end
    if (sw_ack) begin ack_cyc.push_back(cyc); ack_upd.push_back(1'b0); end
    if (upd_ack) begin
      ack_cyc.push_back(cyc); ack_upd.push_back(1'b1);
      upd_ack_cnt <= upd_ack_cnt + 1;
    end
    if (sw_ack && upd_ack) overlap_cnt <= overlap_cnt + 1;
    if (mem_en && en_prev) double_en_cnt <= double_en_cnt + 1;
    en_prev <= mem_en;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; sw_req = 1'b0; upd_req = 1'b0; upd_lock = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge one cycle after the ack.
  task automatic sw_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int t_req, output int t_ack);
    int n;
    sw_we = we; sw_addr = a; sw_wdata = d; sw_req = 1'b1; t_req = cyc; n = 0;
    do begin @(negedge clk); n++; end while (!sw_ack && n < 40);
    check("sw_ack_seen", sw_ack, 1'b1);
    t_ack = cyc; sw_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic upd_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output int t_req, output int t_ack);
    int n;
    upd_we = we; upd_addr = a; upd_wdata = d; upd_req = 1'b1; t_req = cyc; n = 0;
    do begin @(negedge clk); n++; end while (!upd_ack && n < 40);
    check("upd_ack_seen", upd_ack, 1'b1);
    t_ack = cyc; upd_req = 1'b0;
    @(negedge clk);
  endtask

  int t3s_r, t3s_a, t3u_r, t3u_a;

  initial begin
    int tr, ta, tr2, ta2, base, abase, t0;
    rst = 1'b1; sw_req = 1'b0; sw_we = 1'b0; sw_addr = '0; sw_wdata = '0;
    upd_req = 1'b0; upd_we = 1'b0; upd_addr = '0; upd_wdata = '0; upd_lock = 1'b0;
    pl_addr = '0; pl_data = '0;
    repeat (3) @(negedge clk);
    check("rst_sw_ack", sw_ack, 1'b0);
    check("rst_upd_ack", upd_ack, 1'b0);
    check("rst_sw_rdata", sw_rdata, ZERO);
    check("rst_upd_rdata", upd_rdata, ZERO);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, ZERO);
    check("rst_mem_wdata", mem_wdata, ZERO);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    preload(15'h0010, PAT_A5);
    preload(15'h0100, PAT_100);
    preload(15'h7FFF, PAT_7FF);

    // 1: single sw read
    base = en_cyc.size();
    sw_txn(1'b0, 15'h0010, ZERO, tr, ta);
    check("t1_en_count", en_cyc.size() - base, 1);
    check("t1_en_cycle", en_cyc[base] - tr, 1);
    check("t1_en_we", en_we[base], 1'b0);
    check("t1_en_addr", en_addr[base], 15'h0010);
    check("t1_ack_lat", ta - tr, 7);
    check("t1_sw_rdata", sw_rdata, PAT_A5);
    check("t1_no_upd_ack", upd_ack_cnt, 0);

    // 2: simultaneous writes after reset, upd wins first
    do_reset();
    base = en_cyc.size();
    fork
      sw_txn(1'b1, 15'h0020, PAT_SW2, tr, ta);
      upd_txn(1'b1, 15'h0030, PAT_UP2, tr2, ta2);
    join
    check("t2_upd_ack_lat", ta2 - tr2, 2);
    check("t2_sw_ack_lat", ta - tr, 5);
    check("t2_upd_en_cycle", en_cyc[base] - tr, 1);
    check("t2_upd_en_addr", en_addr[base], 15'h0030);
    check("t2_upd_en_we", en_we[base], 1'b1);
    check("t2_upd_en_wdata", en_wdata[base], PAT_UP2);
    check("t2_sw_en_cycle", en_cyc[base+1] - tr, 4);
    check("t2_sw_en_addr", en_addr[base+1], 15'h0020);
    check("t2_sw_en_wdata", en_wdata[base+1], PAT_SW2);

    // 3: continuous reads from both, strict alternation
    abase = ack_cyc.size();
    fork
      for (int i = 0; i < 5; i++) begin
        sw_txn(1'b0, 15'h0010, ZERO, t3s_r, t3s_a);
        check("t3_sw_rdata", sw_rdata, PAT_A5);
      end
      for (int j = 0; j < 5; j++) begin
        upd_txn(1'b0, 15'h0100, ZERO, t3u_r, t3u_a);
        check("t3_upd_rdata", upd_rdata, PAT_100);
      end
    join
    check("t3_ack_count", ack_cyc.size() - abase, 10);
    for (int k = 0; k < 10; k++) begin
      check("t3_grant_order", ack_upd[abase+k], (k % 2 == 0) ? 1'b1 : 1'b0);
      if (k > 0) check("t3_ack_spacing", ack_cyc[abase+k] - ack_cyc[abase+k-1], 8);
    end

    // 4: locked upd read-modify-write holds off sw
    base = en_cyc.size();
    fork
      begin
        upd_lock = 1'b1;
        upd_txn(1'b0, 15'h0100, ZERO, tr, ta);
        check("t4_upd_rdata", upd_rdata, PAT_100);
        upd_txn(1'b1, 15'h0100, PAT_W4, tr2, ta2);
        upd_lock = 1'b0;
      end
      sw_txn(1'b0, 15'h0010, ZERO, t3s_r, t3s_a);
    join
    check("t4_upd_rd_ack", ta - tr, 7);
    check("t4_upd_wr_ack", ta2 - tr, 10);
    check("t4_upd_wr_en", en_cyc[base+1] - tr, 9);
    check("t4_upd_wr_we", en_we[base+1], 1'b1);
    check("t4_upd_wr_wdata", en_wdata[base+1], PAT_W4);
    check("t4_sw_en_cycle", en_cyc[base+2] - t3s_r, 12);
    check("t4_sw_en_addr", en_addr[base+2], 15'h0010);
    check("t4_sw_ack_lat", t3s_a - t3s_r, 18);
    check("t4_sw_rdata", sw_rdata, PAT_A5);

    // 5: reset during WAIT discards the read
    abase = ack_cyc.size();
    sw_we = 1'b0; sw_addr = 15'h0010; sw_req = 1'b1; t0 = cyc;
    repeat (3) @(negedge clk);
    check("t5_busy_in_wait", busy, 1'b1);
    rst = 1'b1; sw_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_no_ack", ack_cyc.size() - abase, 0);
    check("t5_sw_rdata_clr", sw_rdata, ZERO);
    check("t5_upd_rdata_clr", upd_rdata, ZERO);
    check("t5_busy_idle", busy, 1'b0);
    check("t5_elapsed", cyc - t0, 14);
    base = en_cyc.size();
    sw_txn(1'b0, 15'h7FFF, ZERO, tr, ta);
    check("t5_ack_lat", ta - tr, 7);
    check("t5_en_addr", en_addr[base], 15'h7FFF);
    check("t5_sw_rdata", sw_rdata, PAT_7FF);

    // 6: upd write at top address, sw reads it back
    upd_txn(1'b0, 15'h7FFF, ZERO, tr, ta);
    check("t6_upd_rdata", upd_rdata, PAT_7FF);
    upd_txn(1'b1, 15'h7FFF, VAL_1234, tr, ta);
    check("t6_upd_wr_lat", ta - tr, 2);
    check("t6_upd_rdata_kept", upd_rdata, PAT_7FF);
    sw_txn(1'b0, 15'h7FFF, ZERO, tr, ta);
    check("t6_sw_lat", ta - tr, 7);
    check("t6_sw_rdata", sw_rdata, VAL_1234);

    check("ack_overlap", overlap_cnt, 0);
    check("mem_en_pulse", double_en_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
